vga_background_multi: RTL and testbench
=======================================

Name: vga_background_multi

Overview:
- Parametrised successor to the two-segment background generator. Drives a scanline from NUM_SEGMENTS packed pixel words, each BPP bits per logical pixel, with a per-segment horizontal pixel stretch.
- Keeps a pattern register and a working shift register per segment, so every active line restarts from the loaded pattern.
- Output is registered. Sits between the bus register file (pattern loads) and the palette lookup.

Parameters:
- NUM_SEGMENTS, 2, number of pattern segments per line (2..8, need not be a power of two)
- BPP, 2, bits per logical pixel (1, 2, 4 or 8; must divide WORD_W)
- WORD_W, 32, pattern word width
- SIZE_W, 6, width of per-segment stretch field

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- h_active  in  1  horizontal active region
- v_active  in  1  vertical active region
- bg_pixels  in  WORD_W  pattern word to load
- bg_load  in  1  load strobe
- bg_load_sel  in  SEG_W  segment addressed by bg_load; SEG_W = max(1, clog2(NUM_SEGMENTS))
- bg_size  in  NUM_SEGMENTS*SIZE_W  packed stretch values; segment k uses bits [k*SIZE_W +: SIZE_W]; clocks per logical pixel = value+1
- bg_color_index  out  BPP  registered colour index
- bg_seg_index  out  SEG_W  registered segment index for the current output pixel

Behaviour:
- Derived values: active = h_active & v_active; PPS = WORD_W/BPP logical pixels per segment.
- Reset: all pattern, staging and working registers = 0; pix_cnt = 0; lpix_cnt = 0; seg = 0; bg_color_index = 0; bg_seg_index = 0.
- Load, normal path:
  - bg_load with bg_load_sel < NUM_SEGMENTS writes bg_pixels into pattern[bg_load_sel].
  - bg_load_sel >= NUM_SEGMENTS: the load is ignored.
- Working registers:
  - While !active, every cycle: working[k] <= pattern[k]. A load in cycle t therefore reaches working in cycle t+1.
  - While active, working registers are never reloaded from pattern. A load mid-line takes effect from the next line.
- Counters while active:
  - last = (pix_cnt == size[seg]).
  - If !last: pix_cnt++.
  - If last: pix_cnt <= 0, and working[seg] rotates left by BPP bits (MSBs wrap into the LSBs).
  - If last and lpix_cnt == PPS-1: lpix_cnt <= 0 and seg advances. Wrap is NUM_SEGMENTS-1 -> 0; the line continues cycling through the segments.
  - If last and lpix_cnt != PPS-1: lpix_cnt++.
- Counters while !active: pix_cnt, lpix_cnt and seg are all forced to 0 (clears on both h_active and v_active drop).
- Output, 1-cycle latency:
  - bg_color_index <= active ? working[seg][WORD_W-1 -: BPP] : 0.
  - bg_seg_index <= active ? seg : 0.
- Size 0 gives one clock per logical pixel; a line then spans PPS*NUM_SEGMENTS clocks before the pattern repeats.
- Size changes mid-line: compared live, taking effect at the current pix_cnt. If the new size is less than pix_cnt, the counter runs up to 2^SIZE_W-1 and wraps before matching (documented, not guarded).
- Reset mid-line: overrides everything; the next active cycle shows pixel 0 of segment 0 of the zeroed pattern.

Optional Feature:
- Macro: VGA_BG_SHADOW_EN.
- Defined:
  - bg_load writes staging[bg_load_sel] instead of pattern.
  - On the cycle where v_active was 0 last cycle and is 1 now, all staging registers copy into their pattern registers.
  - Pattern changes are thereby frame-atomic.
  - A load in the same cycle as the copy lands in staging and is applied at the next frame.
  - A separate v_active_d register, reset 0, detects the edge.
- Undefined: no staging registers; loads write pattern directly as above.

Test Plan:
- Reset, then load seg0=0xE4000000, seg1=0x1B000000; sizes all 0; active for 32 cycles -> bg_color_index from cycle t+1 reads 3,2,1,0, then 0 x12, then 0,1,2,3, then 0 x12; bg_seg_index switches 0->1 exactly after 16 pixels.
- Size seg0=2 -> each seg0 index is held 3 clocks; seg1 size=0 -> 1 clock each; pix_cnt clears on each segment switch.
- NUM_SEGMENTS=3, BPP=4, 64-cycle active line -> segments 0,1,2 in order, then wrap to seg 0 at pixel 24; bg_seg_index sequence 0,1,2,0.
- Load seg0=0xFFFFFFFF while active -> current line unchanged; next line after an h_active low gap begins with index 3; bg_load_sel=NUM_SEGMENTS -> no register changes.
- Drop h_active mid-segment, then re-raise -> output restarts at the first pixel of seg0 from the pattern; bg_color_index=0 during the gap (one cycle delayed).
- VGA_BG_SHADOW_EN: load during a frame -> output unchanged until after the next v_active rise; load coincident with the rise -> applied one frame later.

Source files
------------

// File: rtl/vga_background_multi.sv
// vga_background_multi
//   Multi-segment scanline background generator. NUM_SEGMENTS packed pattern
//   words of WORD_W bits (BPP bits per logical pixel) are played out in order
//   across the active line. Each segment has its own horizontal stretch.
//   Every segment has a pattern register and a working shift register.
//   Working registers reload from the patterns whenever the display is
//   inactive, so each line restarts from the loaded pattern.
//
//   Optional feature, macro VGA_BG_SHADOW_EN: when defined, loads go to
//   staging registers. All staging registers copy into the patterns on the
//   rising edge of v_active, which makes pattern changes frame-atomic.
//
// Ports
//   clk            : clock
//   reset          : synchronous, active-high reset
//   h_active       : horizontal active region
//   v_active       : vertical active region
//   bg_pixels      : pattern word to load
//   bg_load        : load strobe
//   bg_load_sel    : target segment of a load (out-of-range loads are ignored)
//   bg_size        : packed per-segment stretch, clocks per pixel = value+1
//   bg_color_index : registered colour index
//   bg_seg_index   : registered segment index of the current output pixel
module vga_background_multi #(
  parameter int unsigned NUM_SEGMENTS = 2,
  parameter int unsigned BPP          = 2,
  parameter int unsigned WORD_W       = 32,
  parameter int unsigned SIZE_W       = 6,
  parameter int unsigned SEG_W        = (NUM_SEGMENTS > 1) ? $clog2(NUM_SEGMENTS) : 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           h_active,
  input  logic                           v_active,
  input  logic [WORD_W-1:0]              bg_pixels,
  input  logic                           bg_load,
  input  logic [SEG_W-1:0]               bg_load_sel,
  input  logic [NUM_SEGMENTS*SIZE_W-1:0] bg_size,
  output logic [BPP-1:0]                 bg_color_index,
  output logic [SEG_W-1:0]               bg_seg_index
);

  localparam int unsigned PPS    = WORD_W / BPP;
  localparam int unsigned LPIX_W = (PPS > 1) ? $clog2(PPS) : 1;

  logic [WORD_W-1:0] pattern_q [NUM_SEGMENTS];
  logic [WORD_W-1:0] pattern_d [NUM_SEGMENTS];
  logic [WORD_W-1:0] working_q [NUM_SEGMENTS];
  logic [WORD_W-1:0] working_d [NUM_SEGMENTS];
`ifdef VGA_BG_SHADOW_EN
  logic [WORD_W-1:0] staging_q [NUM_SEGMENTS];
  logic [WORD_W-1:0] staging_d [NUM_SEGMENTS];
  logic              v_active_d_q;
`endif
  logic [SIZE_W-1:0] pix_cnt_q,  pix_cnt_d;
  logic [LPIX_W-1:0] lpix_cnt_q, lpix_cnt_d;
  logic [SEG_W-1:0]  seg_q,      seg_d;
  logic [BPP-1:0]    color_q,    color_d;
  logic [SEG_W-1:0]  seg_idx_q,  seg_idx_d;

  logic              active;
  logic              last;
  logic [SIZE_W-1:0] cur_size;
  logic [WORD_W-1:0] cur_word;

  // Current segment's stretch and working word, selected by a compare loop
  // so a non-power-of-two segment count never indexes out of range.
  always_comb begin
    active   = h_active & v_active;
    cur_size = '0;
    cur_word = '0;
    for (int unsigned k = 0; k < NUM_SEGMENTS; k++) begin
      if (seg_q == SEG_W'(k)) begin
        cur_size = bg_size[k*SIZE_W +: SIZE_W];
        cur_word = working_q[k];
      end
    end
    last = (pix_cnt_q == cur_size);
  end

  // Pattern / staging / working registers
  always_comb begin
    pattern_d = pattern_q;
    working_d = working_q;
`ifdef VGA_BG_SHADOW_EN
    staging_d = staging_q;
    // Copy uses the old staging contents; a load in this cycle waits a frame.
    if (v_active && !v_active_d_q) begin
      pattern_d = staging_q;
    end
    for (int unsigned k = 0; k < NUM_SEGMENTS; k++) begin
      if (bg_load && (bg_load_sel == SEG_W'(k))) begin
        staging_d[k] = bg_pixels;
      end
    end
`else
    for (int unsigned k = 0; k < NUM_SEGMENTS; k++) begin
      if (bg_load && (bg_load_sel == SEG_W'(k))) begin
        pattern_d[k] = bg_pixels;
      end
    end
`endif
    if (!active) begin
      working_d = pattern_q;
    end else if (last) begin
      for (int unsigned k = 0; k < NUM_SEGMENTS; k++) begin
        if (seg_q == SEG_W'(k)) begin
          // Rotate left by BPP; shift form stays valid when BPP == WORD_W.
          working_d[k] = (working_q[k] << BPP) | (working_q[k] >> (WORD_W - BPP));
        end
      end
    end
  end

  // Pixel / logical-pixel / segment counters
  always_comb begin
    pix_cnt_d  = pix_cnt_q;
    lpix_cnt_d = lpix_cnt_q;
    seg_d      = seg_q;
    if (!active) begin
      pix_cnt_d  = '0;
      lpix_cnt_d = '0;
      seg_d      = '0;
    end else if (!last) begin
      pix_cnt_d = pix_cnt_q + 1'b1;
    end else begin
      pix_cnt_d = '0;
      if (lpix_cnt_q == LPIX_W'(PPS - 1)) begin
        lpix_cnt_d = '0;
        seg_d      = (seg_q == SEG_W'(NUM_SEGMENTS - 1)) ? '0 : seg_q + 1'b1;
      end else begin
        lpix_cnt_d = lpix_cnt_q + 1'b1;
      end
    end
  end

  // Registered outputs
  always_comb begin
    color_d   = active ? cur_word[WORD_W-1 -: BPP] : '0;
    seg_idx_d = active ? seg_q : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pattern_q    <= '{default: '0};
      working_q    <= '{default: '0};
`ifdef VGA_BG_SHADOW_EN
      staging_q    <= '{default: '0};
      v_active_d_q <= 1'b0;
`endif
      pix_cnt_q    <= '0;
      lpix_cnt_q   <= '0;
      seg_q        <= '0;
      color_q      <= '0;
      seg_idx_q    <= '0;
    end else begin
      pattern_q    <= pattern_d;
      working_q    <= working_d;
`ifdef VGA_BG_SHADOW_EN
      staging_q    <= staging_d;
      v_active_d_q <= v_active;
`endif
      pix_cnt_q    <= pix_cnt_d;
      lpix_cnt_q   <= lpix_cnt_d;
      seg_q        <= seg_d;
      color_q      <= color_d;
      seg_idx_q    <= seg_idx_d;
    end
  end

  assign bg_color_index = color_q;
  assign bg_seg_index   = seg_idx_q;

endmodule

// File: tb/tb_vga_background_multi.sv
// tb_vga_background_multi
//   Directed bench for vga_background_multi (default build). One instance with
//   default parameters (2 segments, 2 bpp) and one with 3 segments, 4 bpp.
module tb_vga_background_multi;

  logic        clk = 1'b0;
  logic        reset;

  // Default instance: NUM_SEGMENTS=2, BPP=2
  logic        h_active, v_active;
  logic [31:0] bg_pixels;
  logic        bg_load;
  logic [0:0]  bg_load_sel;
  logic [11:0] bg_size;
  logic [1:0]  bg_color_index;
  logic [0:0]  bg_seg_index;

  // Second instance: NUM_SEGMENTS=3, BPP=4
  logic        h3, v3;
  logic [31:0] pix3;
  logic        load3;
  logic [1:0]  sel3;
  logic [17:0] size3;
  logic [3:0]  color3;
  logic [1:0]  segi3;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 clk = ~clk;

  vga_background_multi u_dut (
    .clk            (clk),
    .reset          (reset),
    .h_active       (h_active),
    .v_active       (v_active),
    .bg_pixels      (bg_pixels),
    .bg_load        (bg_load),
    .bg_load_sel    (bg_load_sel),
    .bg_size        (bg_size),
    .bg_color_index (bg_color_index),
    .bg_seg_index   (bg_seg_index)
  );

  vga_background_multi #(
    .NUM_SEGMENTS (3),
    .BPP          (4),
    .WORD_W       (32),
    .SIZE_W       (6)
  ) u_dut3 (
    .clk            (clk),
    .reset          (reset),
    .h_active       (h3),
    .v_active       (v3),
    .bg_pixels      (pix3),
    .bg_load        (load3),
    .bg_load_sel    (sel3),
    .bg_size        (size3),
    .bg_color_index (color3),
    .bg_seg_index   (segi3)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Logical pixel j (from the MSB end) of a 32-bit pattern word
  function automatic logic [31:0] pix(input logic [31:0] w, input int unsigned bpp,
                                      input int unsigned j);
    logic [31:0] mask;
    mask = (32'd1 << bpp) - 32'd1;
    return (w >> (32 - bpp * (j + 1))) & mask;
  endfunction

  localparam logic [31:0] P0  = 32'hE400_0000;
  localparam logic [31:0] P1  = 32'h1B00_0000;
  localparam logic [31:0] Q0  = 32'h0123_4567;
  localparam logic [31:0] Q1  = 32'h89AB_CDEF;
  localparam logic [31:0] Q2  = 32'hFEDC_BA98;

  initial begin
    logic [31:0] w;
    int unsigned s;

    reset = 1'b1; h_active = 0; v_active = 0; bg_pixels = '0; bg_load = 0;
    bg_load_sel = '0; bg_size = '0;
    h3 = 0; v3 = 0; pix3 = '0; load3 = 0; sel3 = '0; size3 = '0;
    tick(); tick();
    chk("reset_color", 32'(bg_color_index), 0);
    chk("reset_seg",   32'(bg_seg_index), 0);
    chk("reset_color3", 32'(color3), 0);
    chk("reset_seg3",   32'(segi3), 0);
    reset = 1'b0;

    // Two-segment line, size 0
    bg_load = 1; bg_load_sel = 0; bg_pixels = P0; tick();
    bg_load_sel = 1; bg_pixels = P1; tick();
    bg_load = 0; tick();
    h_active = 1; v_active = 1;
    for (int c = 0; c < 32; c++) begin
      tick();
      chk($sformatf("line1_color[%0d]", c), 32'(bg_color_index),
          (c < 16) ? pix(P0, 2, c) : pix(P1, 2, c - 16));
      chk($sformatf("line1_seg[%0d]", c), 32'(bg_seg_index), (c < 16) ? 0 : 1);
    end
    tick();
    chk("line1_wrap_color", 32'(bg_color_index), 3);
    chk("line1_wrap_seg",   32'(bg_seg_index), 0);
    h_active = 0; v_active = 0; tick();
    chk("gap1_color", 32'(bg_color_index), 0);

    // Segment 0 stretched to 3 clocks, segment 1 at 1 clock
    bg_size = {6'd0, 6'd2};
    h_active = 1; v_active = 1;
    for (int c = 0; c < 52; c++) begin
      tick();
      chk($sformatf("size_color[%0d]", c), 32'(bg_color_index),
          (c < 48) ? pix(P0, 2, c / 3) : pix(P1, 2, c - 48));
      if (c == 47 || c == 48)
        chk($sformatf("size_seg[%0d]", c), 32'(bg_seg_index), (c < 48) ? 0 : 1);
    end
    h_active = 0; v_active = 0; tick();
    bg_size = '0;

    // Mid-line load: current line unchanged, next line uses the new word
    h_active = 1; v_active = 1;
    tick(); chk("midload_c0", 32'(bg_color_index), 3);
    tick(); chk("midload_c1", 32'(bg_color_index), 2);
    bg_load = 1; bg_load_sel = 0; bg_pixels = 32'hFFFF_FFFF;
    tick(); chk("midload_c2", 32'(bg_color_index), 1);
    bg_load = 0;
    for (int c = 3; c < 8; c++) begin
      tick(); chk($sformatf("midload_c%0d", c), 32'(bg_color_index), 0);
    end
    h_active = 0;
    tick(); chk("midload_gap", 32'(bg_color_index), 0);
    h_active = 1;
    tick(); chk("newline_c0", 32'(bg_color_index), 3);
    tick(); chk("newline_c1", 32'(bg_color_index), 3);
    chk("newline_seg", 32'(bg_seg_index), 0);
    h_active = 0; v_active = 0;

    // h_active drop mid-segment restarts from pixel 0 of segment 0
    bg_load = 1; bg_load_sel = 0; bg_pixels = P0; tick();
    bg_load = 0; tick();
    h_active = 1; v_active = 1;
    for (int c = 0; c < 5; c++) begin
      tick(); chk($sformatf("drop_pre[%0d]", c), 32'(bg_color_index), pix(P0, 2, c));
    end
    h_active = 0;
    tick(); chk("drop_gap0", 32'(bg_color_index), 0);
    tick(); chk("drop_gap1", 32'(bg_color_index), 0);
    chk("drop_gap_seg", 32'(bg_seg_index), 0);
    h_active = 1;
    for (int c = 0; c < 3; c++) begin
      tick(); chk($sformatf("drop_post[%0d]", c), 32'(bg_color_index), pix(P0, 2, c));
    end

    // Reset mid-line clears patterns and outputs
    reset = 1;
    tick(); chk("rst_mid_color", 32'(bg_color_index), 0);
    chk("rst_mid_seg", 32'(bg_seg_index), 0);
    reset = 0;
    for (int c = 0; c < 3; c++) begin
      tick(); chk($sformatf("rst_post[%0d]", c), 32'(bg_color_index), 0);
    end
    h_active = 0; v_active = 0; tick();
    h_active = 1; v_active = 1;
    tick(); chk("rst_nextline", 32'(bg_color_index), 0);
    h_active = 0; v_active = 0;

    // Three segments, 4 bpp; load to sel=3 must be ignored
    load3 = 1; sel3 = 0; pix3 = Q0; tick();
    sel3 = 1; pix3 = Q1; tick();
    sel3 = 2; pix3 = Q2; tick();
    sel3 = 3; pix3 = 32'hDEAD_BEEF; tick();
    load3 = 0; tick();
    h3 = 1; v3 = 1;
    for (int c = 0; c < 64; c++) begin
      tick();
      s = (c / 8) % 3;
      w = (s == 0) ? Q0 : (s == 1) ? Q1 : Q2;
      chk($sformatf("seg3_color[%0d]", c), 32'(color3), pix(w, 4, c % 8));
      chk($sformatf("seg3_seg[%0d]", c), 32'(segi3), s);
    end
    h3 = 0;
    tick(); chk("seg3_gap", 32'(color3), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
